// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider scheduler.
// State encoding, factor width and the winner-to-one-hot map.
package clk_div_pkg;

   localparam int FACTOR_W = 4;
   localparam int IDX_W    = 3;
   localparam int MAX_REQ  = 8;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RUN,
      DONE
   } state_t;

   function automatic logic [MAX_REQ-1:0] onehot(
      input logic [IDX_W-1:0] idx
   );
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Requester/divider bundle between the scheduler and its clients.
// master drives requests; slave is the scheduler.
interface clk_div_sched_if
   import clk_div_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PW    = 8
);

   logic [N_REQ-1:0]          req;
   logic [FACTOR_W*N_REQ-1:0] factor_in;
   logic [PW*N_REQ-1:0]       periods_in;
   logic [N_REQ-1:0]          grant;
   logic [N_REQ-1:0]          ack;
   logic [N_REQ-1:0]          err;
   logic [FACTOR_W-1:0]       div_factor;
   logic                      div_rst;
   logic                      busy;

   modport master (
      output req, factor_in, periods_in,
      input  grant, ack, err, div_factor, div_rst, busy
   );

   modport slave (
      input  req, factor_in, periods_in,
      output grant, ack, err, div_factor, div_rst, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting at rr_ptr.
// Lowest offset from the pointer wins.
module rr_arbiter
   import clk_div_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         logic [IDX_W:0] sum;
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N_REQ))
            sum = sum - (IDX_W+1)'(N_REQ);
         for (int i = 0; i < N_REQ; i++) begin
            if (sum[IDX_W-1:0] == IDX_W'(i) && req[i]) begin
               winner = IDX_W'(i);
               valid  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/clk_div_sched.sv
// Time-shares one external clock divider among N_REQ requesters,
// counting each owner's dwell on a mirror of the divider counter.
module clk_div_sched
   import clk_div_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PW    = 8
) (
   input logic          clk_ip,
   input logic          rst,
   clk_div_sched_if.slave bus
);

   state_t              state, nxt;
   logic [IDX_W-1:0]    rr_ptr, owner, win;
   logic                win_valid;
   logic [FACTOR_W-1:0] f_q, cnt, f_sel, div_factor_q;
   logic [PW-1:0]       p_q, p_sel;
   logic [PW:0]         toggles, tog_next;
   logic [N_REQ-1:0]    grant_q, ack_q, err_q;
   logic                sel_ok, owner_req, cnt_wrap, last_tog;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .winner (win),
      .valid  (win_valid)
   );

   function automatic logic [IDX_W-1:0] ptr_inc(
      input logic [IDX_W-1:0] i
   );
      if ({1'b0, i} + 1'b1 >= (IDX_W+1)'(N_REQ))
         return '0;
      return i + 1'b1;
   endfunction

   always_comb begin
      f_sel     = '0;
      p_sel     = '0;
      owner_req = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win == IDX_W'(i)) begin
            f_sel = bus.factor_in[i*FACTOR_W +: FACTOR_W];
            p_sel = bus.periods_in[i*PW +: PW];
         end
         if (owner == IDX_W'(i))
            owner_req = bus.req[i];
      end
   end

   assign sel_ok   = (f_sel != '0) && (p_sel != '0);
   assign cnt_wrap = (cnt == f_q - 4'd1);
   assign tog_next = toggles + 1'b1;
   assign last_tog = cnt_wrap && (tog_next == {p_q, 1'b0});

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:
            if (win_valid && err_q == '0 && sel_ok)
               nxt = GRANT;
         GRANT:
            nxt = owner_req ? RUN : IDLE;
         RUN:
            if (!owner_req)    nxt = IDLE;
            else if (last_tog) nxt = DONE;
         DONE:
            nxt = IDLE;
         default:
            nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_ip or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         f_q          <= '0;
         p_q          <= '0;
         cnt          <= '0;
         toggles      <= '0;
         grant_q      <= '0;
         ack_q        <= '0;
         err_q        <= '0;
         div_factor_q <= 4'd1;
      end else begin
         state <= nxt;
         ack_q <= '0;
         err_q <= '0;
         unique case (state)
            IDLE:
               // skip the err cycle so a still-held bad request is not re-judged
               if (win_valid && err_q == '0) begin
                  if (!sel_ok) begin
                     err_q  <= N_REQ'(onehot(win));
                     rr_ptr <= ptr_inc(win);
                  end else begin
                     owner        <= win;
                     f_q          <= f_sel;
                     p_q          <= p_sel;
                     div_factor_q <= f_sel;
                     grant_q      <= N_REQ'(onehot(win));
                  end
               end
            GRANT: begin
               cnt     <= '0;
               toggles <= '0;
               if (!owner_req) begin
                  grant_q <= '0;
                  rr_ptr  <= ptr_inc(owner);
               end
            end
            RUN:
               if (!owner_req) begin
                  grant_q <= '0;
                  rr_ptr  <= ptr_inc(owner);
               end else begin
                  if (cnt_wrap) begin
                     cnt     <= '0;
                     toggles <= tog_next;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
                  if (last_tog) begin
                     grant_q <= '0;
                     ack_q   <= N_REQ'(onehot(owner));
                     rr_ptr  <= ptr_inc(owner);
                  end
               end
            default: ;
         endcase
      end
   end

   assign bus.grant      = grant_q;
   assign bus.ack        = ack_q;
   assign bus.err        = err_q;
   assign bus.div_factor = div_factor_q;
   assign bus.div_rst    = (state != RUN);
   assign bus.busy       = (state == GRANT) || (state == RUN);

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched with an external divider model and a
// transaction-level round-robin reference for random request sets.
module tb_clk_div_sched;

   localparam int N  = 4;
   localparam int PW = 8;

   logic clk_ip;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   model_ptr;

   clk_div_sched_if #(.N_REQ(N), .PW(PW)) bus ();

   clk_div_sched #(.N_REQ(N), .PW(PW)) dut (
      .clk_ip (clk_ip),
      .rst    (rst),
      .bus    (bus.slave)
   );

   // external divider next to the scheduler
   logic [3:0] dcnt;
   logic       dout;
   always @(posedge clk_ip or posedge bus.div_rst) begin
      if (bus.div_rst) begin
         dcnt <= 4'd0;
         dout <= 1'b0;
      end else if (dcnt == bus.div_factor - 4'd1) begin
         dcnt <= 4'd0;
         dout <= ~dout;
      end else begin
         dcnt <= dcnt + 4'd1;
      end
   end

   initial clk_ip = 1'b0;
   always #5 clk_ip = ~clk_ip;

   task automatic step();
      @(posedge clk_ip);
      #1;
   endtask

   task automatic set_in(input int i, input logic [3:0] f,
                         input logic [7:0] p);
      bus.factor_in[i*4 +: 4]   = f;
      bus.periods_in[i*PW +: PW] = p;
   endtask

   task automatic apply_reset();
      bus.req = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      model_ptr = 0;
   endtask

   task automatic serve(input int budget, output int idx, output int run,
                        output int tog, output int pre,
                        output logic [N-1:0] ackv, output logic dout_ack,
                        output bit timeout);
      int   n;
      bit   started;
      logic prev;
      idx = -1; run = 0; tog = 0; ackv = '0;
      dout_ack = 1'b0; timeout = 1'b0; n = 0; started = 1'b0;
      pre = bus.div_rst ? 1 : 0;
      while (bus.grant == '0 && n < budget) begin
         step(); n++;
         if (bus.div_rst) pre++;
      end
      if (bus.grant == '0) begin
         timeout = 1'b1;
         return;
      end
      for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
      prev = dout;
      while (bus.ack == '0 && n < budget) begin
         step(); n++;
         if (!bus.div_rst) begin
            run++;
            started = 1'b1;
         end else if (!started) begin
            pre++;
         end
         if (dout !== prev) tog++;
         prev = dout;
      end
      if (bus.ack == '0) begin
         timeout = 1'b1;
         return;
      end
      ackv = bus.ack;
      dout_ack = dout;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = '0;
      #3;
      n_cmp++;
      if (bus.grant !== '0 || bus.ack !== '0 || bus.err !== '0) begin
         n_bad++;
         $display("FAIL reset_vec: grant=%b ack=%b err=%b want 0",
                  bus.grant, bus.ack, bus.err);
      end
      n_cmp++;
      if (bus.div_factor !== 4'd1 || bus.div_rst !== 1'b1 ||
          bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_div: factor=%0d div_rst=%b busy=%b want 1/1/0",
                  bus.div_factor, bus.div_rst, bus.busy);
      end
      apply_reset();
   endtask

   task automatic test_single();
      int idx, run, tog, pre;
      logic [N-1:0] ackv;
      logic da;
      bit to;
      apply_reset();
      set_in(0, 4'd3, 8'd2);
      bus.req = 4'b0001;
      step();
      n_cmp++;
      if (bus.grant !== 4'b0001 || bus.div_factor !== 4'd3 ||
          bus.div_rst !== 1'b1 || bus.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL single_edge1: grant=%b factor=%0d div_rst=%b busy=%b want 0001/3/1/1",
                  bus.grant, bus.div_factor, bus.div_rst, bus.busy);
      end
      set_in(0, 4'd7, 8'd9);
      serve(200, idx, run, tog, pre, ackv, da, to);
      n_cmp++;
      if (to || run != 12 || ackv !== 4'b0001) begin
         n_bad++;
         $display("FAIL single_run: timeout=%0d run=%0d ack=%b want 0/12/0001",
                  to, run, ackv);
      end
      n_cmp++;
      if (tog != 4 || da !== 1'b0) begin
         n_bad++;
         $display("FAIL single_div: toggles=%0d out=%b want 4/0", tog, da);
      end
      n_cmp++;
      if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.div_rst !== 1'b1) begin
         n_bad++;
         $display("FAIL single_done: grant=%b busy=%b div_rst=%b want 0/0/1",
                  bus.grant, bus.busy, bus.div_rst);
      end
      bus.req = '0;
      step();
      n_cmp++;
      if (bus.ack !== '0) begin
         n_bad++;
         $display("FAIL single_ack_pulse: ack=%b want 0000", bus.ack);
      end
   endtask

   task automatic test_back_to_back();
      int idx, run, tog, pre;
      logic [N-1:0] ackv;
      logic da;
      bit to;
      apply_reset();
      for (int i = 0; i < N; i++) set_in(i, 4'd2, 8'd1);
      bus.req = 4'b1111;
      for (int k = 0; k < N; k++) begin
         serve(100, idx, run, tog, pre, ackv, da, to);
         n_cmp++;
         if (to || idx != k || run != 4 || ackv !== 4'(1 << k) || pre < 2) begin
            n_bad++;
            $display("FAIL b2b_owner%0d: timeout=%0d idx=%0d run=%0d ack=%b gap=%0d want idx %0d run 4 gap>=2",
                     k, to, idx, run, ackv, pre, k);
         end
         bus.req[k] = 1'b0;
      end
      step();
   endtask

   task automatic test_invalid();
      apply_reset();
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) set_in(2, 4'd0, 8'd5);
         else           set_in(2, 4'd3, 8'd0);
         bus.req = 4'b0100;
         step();
         n_cmp++;
         if (bus.err !== 4'b0100 || bus.grant !== '0 ||
             bus.div_rst !== 1'b1 || bus.ack !== '0) begin
            n_bad++;
            $display("FAIL invalid%0d_err: err=%b grant=%b div_rst=%b ack=%b want 0100/0/1/0",
                     pass, bus.err, bus.grant, bus.div_rst, bus.ack);
         end
         bus.req = '0;
         step();
         n_cmp++;
         if (bus.err !== '0 || bus.grant !== '0 || bus.div_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL invalid%0d_after: err=%b grant=%b div_rst=%b want 0/0/1",
                     pass, bus.err, bus.grant, bus.div_rst);
         end
      end
   endtask

   task automatic test_abort();
      bit seen_ack;
      apply_reset();
      set_in(1, 4'd5, 8'd3);
      set_in(0, 4'd1, 8'd1);
      set_in(2, 4'd1, 8'd1);
      bus.req = 4'b0010;
      seen_ack = 1'b0;
      step();
      for (int c = 0; c < 7; c++) begin
         step();
         if (bus.ack != '0) seen_ack = 1'b1;
      end
      n_cmp++;
      if (bus.div_rst !== 1'b0 || bus.grant !== 4'b0010) begin
         n_bad++;
         $display("FAIL abort_running: div_rst=%b grant=%b want 0/0010",
                  bus.div_rst, bus.grant);
      end
      bus.req = '0;
      step();
      if (bus.ack != '0) seen_ack = 1'b1;
      n_cmp++;
      if (bus.div_rst !== 1'b1 || bus.grant !== '0 || bus.busy !== 1'b0 ||
          seen_ack) begin
         n_bad++;
         $display("FAIL abort_idle: div_rst=%b grant=%b busy=%b ack_seen=%0d want 1/0/0/0",
                  bus.div_rst, bus.grant, bus.busy, seen_ack);
      end
      bus.req = 4'b0101;
      step();
      n_cmp++;
      if (bus.grant !== 4'b0100) begin
         n_bad++;
         $display("FAIL abort_rr_ptr: grant=%b want 0100", bus.grant);
      end
      bus.req = '0;
      step();
   endtask

   task automatic test_reset_mid_run();
      int idx, run, tog, pre;
      logic [N-1:0] ackv;
      logic da;
      bit to;
      apply_reset();
      set_in(0, 4'd4, 8'd3);
      bus.req = 4'b0001;
      for (int c = 0; c < 5; c++) step();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.grant !== '0 || bus.div_rst !== 1'b1 || bus.busy !== 1'b0 ||
          bus.ack !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_run: grant=%b div_rst=%b busy=%b ack=%b want 0/1/0/0",
                  bus.grant, bus.div_rst, bus.busy, bus.ack);
      end
      bus.req = '0;
      step();
      rst = 1'b0;
      step();
      model_ptr = 0;
      bus.req = 4'b0001;
      serve(200, idx, run, tog, pre, ackv, da, to);
      n_cmp++;
      if (to || run != 24 || ackv !== 4'b0001 || tog != 6) begin
         n_bad++;
         $display("FAIL rst_recover: timeout=%0d run=%0d ack=%b tog=%0d want 0/24/0001/6",
                  to, run, ackv, tog);
      end
      bus.req = '0;
      step();
   endtask

   task automatic test_factor_one();
      int idx, run, tog, pre;
      logic [N-1:0] ackv;
      logic da;
      bit to;
      apply_reset();
      set_in(0, 4'd1, 8'd255);
      bus.req = 4'b0001;
      serve(700, idx, run, tog, pre, ackv, da, to);
      n_cmp++;
      if (to || run != 510 || tog != 510 || ackv !== 4'b0001 || da !== 1'b0) begin
         n_bad++;
         $display("FAIL factor_one: timeout=%0d run=%0d tog=%0d ack=%b out=%b want 0/510/510/0001/0",
                  to, run, tog, ackv, da);
      end
      bus.req = '0;
      step();
   endtask

   task automatic test_random();
      apply_reset();
      for (int r = 0; r < 10; r++) begin
         logic [N-1:0] mask, pend;
         int f[N];
         int p[N];
         int ev_idx[$];
         int ev_run[$];
         bit ev_err[$];
         int ptr;
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) begin
            f[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15);
            p[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 5);
            set_in(i, 4'(f[i]), 8'(p[i]));
         end
         pend = mask;
         ptr = model_ptr;
         while (pend != '0) begin
            int w;
            w = -1;
            for (int k = N - 1; k >= 0; k--)
               if (pend[(ptr + k) % N]) w = (ptr + k) % N;
            ev_idx.push_back(w);
            ev_err.push_back(f[w] == 0 || p[w] == 0);
            ev_run.push_back(2 * p[w] * f[w]);
            pend[w] = 1'b0;
            ptr = (w + 1) % N;
         end
         model_ptr = ptr;
         bus.req = mask;
         while (ev_idx.size() > 0) begin
            int w, n, run;
            bit e;
            w = ev_idx.pop_front();
            e = ev_err.pop_front();
            n = 0;
            run = 0;
            do begin
               step(); n++;
               if (!bus.div_rst) run++;
            end while (bus.err == '0 && bus.ack == '0 && n < 400);
            n_cmp++;
            if (e && (bus.err !== 4'(1 << w) || bus.ack !== '0)) begin
               n_bad++;
               $display("FAIL rnd%0d_err: err=%b ack=%b want err %b",
                        r, bus.err, bus.ack, 4'(1 << w));
            end else if (!e && (bus.ack !== 4'(1 << w) ||
                                run != ev_run[0])) begin
               n_bad++;
               $display("FAIL rnd%0d_ack: ack=%b run=%0d want ack %b run %0d",
                        r, bus.ack, run, 4'(1 << w), ev_run[0]);
            end
            void'(ev_run.pop_front());
            if (bus.err == '0 && bus.ack == '0) begin
               bus.req = '0;
               apply_reset();
               break;
            end
            bus.req = bus.req & ~(bus.err | bus.ack);
         end
         bus.req = '0;
         step();
         step();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      model_ptr = 0;
      rst = 1'b1;
      bus.req = '0;
      bus.factor_in = '0;
      bus.periods_in = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_invalid();
      test_abort();
      test_reset_mid_run();
      test_factor_one();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
